register_file_mp: RTL and testbench

- Parametrised, dual-write-port successor to the single-cycle datapath register file.
- Provides two combinational read ports, with the PC register index aliased to the external R15 input.
- Provides two synchronous write ports: WE3 for the ALU result, WE4 for the load/base writeback.
- Adds a software-triggered clear sequencer that zeroes the array one register per cycle, and reports progress on BUSY.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_clear_seq.sv | 70 +++++++
 rtl/register_file_mp.sv | 96 +++++++++
 tb/tb_register_file_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and default geometry for the multi-port register file.
// Optional build macro: RF_BYPASS_EN (write-through read forwarding).
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int PC_IDX   = 15;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every stored register index once (skipping the
// PC alias), one per cycle, and flags the sweep on busy / clr_en.
module rf_clear_seq #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int PC_IDX   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);
  import rf_pkg::*;

  // First and last stored indices; the PC alias never holds storage.
  localparam int FIRST = (PC_IDX == 0) ? 1 : 0;
  localparam int LAST  = (PC_IDX == NUM_REGS - 1) ? NUM_REGS - 2 : NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] FIRST_A = FIRST[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_A  = LAST[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_A    = PC_IDX[ADDR_W-1:0];

  rf_state_e         state;
  logic [ADDR_W-1:0] cnt;

  function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] c);
    logic [ADDR_W-1:0] n;
    n = c + 1'b1;
    if (n == PC_A) n = n + 1'b1;
    return n;
  endfunction

  // Sweep FSM with registered busy flag; CLR is ignored once sweeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          if (clr) begin
            state <= RF_SWEEP;
            cnt   <= FIRST_A;
            busy  <= 1'b1;
          end
        end
        RF_SWEEP: begin
          if (cnt == LAST_A) begin
            state <= RF_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= next_idx(cnt);
          end
        end
        default: begin
          state <= RF_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/register_file_mp.sv
// Dual-read / dual-write register file with PC alias on PC_IDX and a
// one-register-per-cycle clear sweep.
// Optional build macro: RF_BYPASS_EN (same-cycle write data forwarded to reads).
module register_file_mp #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int PC_IDX   = rf_pkg::PC_IDX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic [DATA_W-1:0] R15,
  input  logic              CLR,
  output logic              BUSY
);
  import rf_pkg::*;

  localparam logic [ADDR_W:0]   NREGS = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PC_A  = PC_IDX[ADDR_W-1:0];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              ok3, ok4;
  logic [DATA_W-1:0] q_arr [NUM_REGS];

  rf_clear_seq #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .PC_IDX   (PC_IDX)
  ) u_clr (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (CLR),
    .busy     (BUSY),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS) && (a != PC_A);
  endfunction

  // Writes are dropped outright while the sweep owns the array.
  assign ok3 = WE3 && legal(A3) && !BUSY;
  assign ok4 = WE4 && legal(A4) && !BUSY;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == PC_IDX) begin : g_pc
      assign q_arr[i] = '0;
    end else begin : g_st
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      logic [DATA_W-1:0] q;
      // Per-register commit: sweep clear, then port 4, then port 3.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                         q <= '0;
        else if (clr_en && clr_addr == IDX) q <= '0;
        else if (ok4 && A4 == IDX)          q <= WD4;
        else if (ok3 && A3 == IDX)          q <= WD3;
      end
      assign q_arr[i] = q;
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == PC_A) begin
      v = R15;
    end else if ({1'b0, a} < NREGS) begin
`ifdef RF_BYPASS_EN
      if (ok4 && A4 == a)      v = WD4;
      else if (ok3 && A3 == a) v = WD3;
      else
`endif
      v = q_arr[a];
    end
    return v;
  endfunction

  // Combinational read ports.
  always_comb begin
    RD1 = rd(A1);
    RD2 = rd(A2);
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (default geometry).
module tb_register_file_mp;

  logic        CLK, RESET;
  logic [3:0]  A1, A2, A3, A4;
  logic [31:0] RD1, RD2, WD3, WD4, R15;
  logic        WE3, WE4, CLR, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural reference state
  logic [31:0] model [16];
  int          sw_left;
  int          sw_idx;

  register_file_mp dut (
    .CLK(CLK), .RESET(RESET), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4),
    .R15(R15), .CLR(CLR), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [3:0] a);
    if (a == 4'd15) return R15;
`ifdef RF_BYPASS_EN
    if (sw_left == 0) begin
      if (WE4 && A4 == a) return WD4;
      if (WE3 && A3 == a) return WD3;
    end
`endif
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    sw_left = 0;
    sw_idx  = 0;
  endtask

  // Apply the effect of the coming edge to the model, then advance.
  task automatic tick();
    if (sw_left > 0) begin
      model[sw_idx] = 32'h0;
      sw_idx++;
      if (sw_idx == 15) sw_idx++;
      sw_left--;
    end else begin
      if (CLR) begin
        sw_left = 15;
        sw_idx  = 0;
      end
      if (WE4 && A4 != 4'd15) model[A4] = WD4;
      if (WE3 && A3 != 4'd15 && !(WE4 && A4 == A3)) model[A3] = WD3;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_rd1"}, RD1, ref_rd(A1));
    check({tag, "_rd2"}, RD2, ref_rd(A2));
  endtask

  task automatic idle_inputs();
    WE3 = 1'b0; WE4 = 1'b0; CLR = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      A1 = 4'(i);
      A2 = 4'(15 - i);
      check_reads(tag);
    end
  endtask

  task automatic count_sweep(input string tag, input bit poke);
    int n;
    n = 0;
    CLR = 1'b1;
    tick();
    CLR = 1'b1;                       // CLR during sweep must be ignored
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      if (n == 2) CLR = 1'b0;
      WE3 = 1'b0;
      if (poke && n == 4) begin
        WE3 = 1'b1; A3 = 4'd3; WD3 = 32'h77;
      end
      if (n == 5) begin
        A1 = 4'd0; A2 = 4'd14;
        check_reads({tag, "_mid"});
      end
      tick();
    end
    idle_inputs();
    check({tag, "_busy_len"}, 32'(n), 32'd15);
  endtask

  initial begin
    RESET = 1'b1;
    A1 = '0; A2 = '0; A3 = '0; A4 = '0;
    WD3 = '0; WD4 = '0; R15 = 32'h0000_0108;
    idle_inputs();
    model_reset();
    #12;
    check("rst_busy", 32'(BUSY), 32'd0);
    A1 = 4'd0; A2 = 4'd14;
    check_reads("rst");
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Basic write / read and PC alias
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    A1 = 4'd2; A2 = 4'd15;
    check_reads("basic");
    check("basic_rd1_lit", RD1, 32'hDEAD_BEEF);
    check("basic_rd2_pc", RD2, 32'h0000_0108);

    // Same-address collision: port 4 wins
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'h11;
    WE4 = 1'b1; A4 = 4'd5; WD4 = 32'h22;
    tick();
    idle_inputs();
    A1 = 4'd5; A2 = 4'd2;
    check_reads("coll");
    check("coll_lit", RD1, 32'h22);

    // Write to PC index dropped
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h55;
    tick();
    idle_inputs();
    R15 = 32'h0000_0200;
    check_all("pcwr");

    // Fill then sweep
    for (int i = 0; i < 15; i++) begin
      WE4 = 1'b1; A4 = 4'(i); WD4 = 32'(i + 1);
      tick();
    end
    idle_inputs();
    check_all("fill");
    count_sweep("sweep", 1'b1);
    check_all("swept");

    // Async reset in the middle of a sweep
    for (int i = 0; i < 15; i++) begin
      WE4 = 1'b1; A4 = 4'(i); WD4 = 32'(i * 3 + 7);
      tick();
    end
    idle_inputs();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", 32'(BUSY), 32'd1);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check("midrst_busy", 32'(BUSY), 32'd0);
    check_all("midrst");
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    count_sweep("resweep", 1'b0);

    // Forwarding (or not) of same-cycle writes
    WE4 = 1'b1; A4 = 4'd7; WD4 = 32'h0000_1234;
    tick();
    WE4 = 1'b1; A4 = 4'd7; WD4 = 32'hA5A5_A5A5;
    A1 = 4'd7; A2 = 4'd7;
    check_reads("byp");
`ifdef RF_BYPASS_EN
    check("byp_lit", RD1, 32'hA5A5_A5A5);
`else
    check("byp_lit", RD1, 32'h0000_1234);
`endif
    tick();
    idle_inputs();
    check_reads("byp_after");
    check("byp_after_lit", RD1, 32'hA5A5_A5A5);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      A1  = 4'($urandom_range(0, 15));
      A2  = 4'($urandom_range(0, 15));
      WE3 = 1'($urandom_range(0, 1));
      A3  = 4'($urandom_range(0, 15));
      WD3 = $urandom;
      WE4 = 1'($urandom_range(0, 1));
      A4  = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom_range(0, 15));
      WD4 = $urandom;
      R15 = $urandom;
      CLR = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) A1 = A4;
      check_reads("rnd");
      check("rnd_busy", 32'(BUSY), 32'(sw_left > 0));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) tick();
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
